// File: rtl/mem_initiator.sv
// Bus master for the memory block: buffers read/write commands in a small FIFO and issues them
// one at a time on a valid/ready port, returning read data and aborting unacknowledged requests.
module mem_initiator #(
    parameter int unsigned ADDR_WIDTH = 6,
    parameter int unsigned DATA_WIDTH = 16,
    parameter int unsigned FIFO_DEPTH = 4,
    parameter int unsigned TIMEOUT    = 15
) (
    input  logic                  clk,
    input  logic                  rst,
    // command port
    input  logic                  cmd_valid,
    output logic                  cmd_ready,
    input  logic                  cmd_wr_rd,
    input  logic [ADDR_WIDTH-1:0] cmd_addr,
    input  logic [DATA_WIDTH-1:0] cmd_wdata,
    // memory port
    output logic [ADDR_WIDTH-1:0] addr,
    output logic                  wr_rd,
    output logic [DATA_WIDTH-1:0] wdata,
    output logic                  valid,
    input  logic                  ready,
    input  logic [DATA_WIDTH-1:0] rdata,
    // response and status
    output logic                  rsp_valid,
    output logic [ADDR_WIDTH-1:0] rsp_addr,
    output logic [DATA_WIDTH-1:0] rsp_data,
    output logic                  rsp_err,
    output logic                  timeout_err,
    output logic                  busy,
    output logic [15:0]           wr_done,
    output logic [15:0]           rd_done
);

    localparam int unsigned PtrW   = $clog2(FIFO_DEPTH);
    localparam int unsigned CntW   = $clog2(TIMEOUT + 1);
    localparam int unsigned EntryW = 1 + ADDR_WIDTH + DATA_WIDTH;

    typedef enum logic [0:0] {StIdle, StReq} state_e;

    state_e state_q, state_d;

    logic [EntryW-1:0] fifo_mem [FIFO_DEPTH];
    logic [PtrW:0]     wr_ptr_q, rd_ptr_q;
    logic              fifo_empty, fifo_full;
    logic              push, pop;
    logic [EntryW-1:0] head;

    logic [CntW-1:0]       wait_q, wait_d;
    logic [ADDR_WIDTH-1:0] addr_q;
    logic                  wr_rd_q;
    logic [DATA_WIDTH-1:0] wdata_q;

    logic                  done_wr, done_rd, drop;
    logic                  rsp_valid_q, rsp_err_q, timeout_err_q;
    logic [ADDR_WIDTH-1:0] rsp_addr_q;
    logic [DATA_WIDTH-1:0] rsp_data_q;
    logic [15:0]           wr_done_q, rd_done_q;

    // Pointers carry one extra wrap bit so full and empty are distinguishable.
    assign fifo_empty = (wr_ptr_q == rd_ptr_q);
    assign fifo_full  = (wr_ptr_q[PtrW] != rd_ptr_q[PtrW]) &&
                        (wr_ptr_q[PtrW-1:0] == rd_ptr_q[PtrW-1:0]);
    assign cmd_ready  = !fifo_full;
    assign push       = cmd_valid && !fifo_full;
    assign head       = fifo_mem[rd_ptr_q[PtrW-1:0]];

    always_ff @(posedge clk) begin
        if (push) begin
            fifo_mem[wr_ptr_q[PtrW-1:0]] <= {cmd_wr_rd, cmd_addr, cmd_wdata};
        end
    end

    always_comb begin
        state_d = state_q;
        wait_d  = wait_q;
        pop     = 1'b0;
        done_wr = 1'b0;
        done_rd = 1'b0;
        drop    = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (!fifo_empty) begin
                    pop     = 1'b1;
                    wait_d  = '0;
                    state_d = StReq;
                end
            end
            StReq: begin
                if (ready) begin
                    done_wr = wr_rd_q;
                    done_rd = !wr_rd_q;
                    state_d = StIdle;
                end else if (wait_q == CntW'(TIMEOUT - 1)) begin
                    // This would be the TIMEOUT-th cycle without ready: abandon the request.
                    drop    = 1'b1;
                    state_d = StIdle;
                end else begin
                    wait_d = wait_q + CntW'(1);
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= StIdle;
            wr_ptr_q      <= '0;
            rd_ptr_q      <= '0;
            wait_q        <= '0;
            addr_q        <= '0;
            wr_rd_q       <= 1'b0;
            wdata_q       <= '0;
            rsp_valid_q   <= 1'b0;
            rsp_err_q     <= 1'b0;
            rsp_addr_q    <= '0;
            rsp_data_q    <= '0;
            timeout_err_q <= 1'b0;
            wr_done_q     <= '0;
            rd_done_q     <= '0;
        end else begin
            state_q <= state_d;
            wait_q  <= wait_d;
            if (push) begin
                wr_ptr_q <= wr_ptr_q + (PtrW + 1)'(1);
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + (PtrW + 1)'(1);
                wr_rd_q  <= head[EntryW-1];
                addr_q   <= head[EntryW-2 -: ADDR_WIDTH];
                wdata_q  <= head[DATA_WIDTH-1:0];
            end

            rsp_valid_q <= done_rd || (drop && !wr_rd_q);
            rsp_err_q   <= drop && !wr_rd_q;
            if (done_rd) begin
                rsp_addr_q <= addr_q;
                rsp_data_q <= rdata;
            end else if (drop && !wr_rd_q) begin
                rsp_addr_q <= addr_q;
                rsp_data_q <= '0;
            end

            if (drop) begin
                timeout_err_q <= 1'b1;
            end
            if (done_wr) begin
                wr_done_q <= wr_done_q + 16'd1;
            end
            if (done_rd) begin
                rd_done_q <= rd_done_q + 16'd1;
            end
        end
    end

    assign addr        = addr_q;
    assign wr_rd       = wr_rd_q;
    assign wdata       = wdata_q;
    assign valid       = (state_q == StReq);
    assign rsp_valid   = rsp_valid_q;
    assign rsp_addr    = rsp_addr_q;
    assign rsp_data    = rsp_data_q;
    assign rsp_err     = rsp_err_q;
    assign timeout_err = timeout_err_q;
    assign busy        = !fifo_empty || (state_q != StIdle);
    assign wr_done     = wr_done_q;
    assign rd_done     = rd_done_q;

endmodule

// File: tb/tb_mem_initiator.sv
// Directed bench for mem_initiator: a behavioural memory answers requests with configurable wait
// states and a scoreboard of expected read responses is checked as responses appear.
module tb_mem_initiator;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        cmd_valid = 1'b0;
    logic        cmd_ready;
    logic        cmd_wr_rd = 1'b0;
    logic [5:0]  cmd_addr = '0;
    logic [15:0] cmd_wdata = '0;
    logic [5:0]  addr;
    logic        wr_rd;
    logic [15:0] wdata;
    logic        valid;
    logic        ready = 1'b0;
    logic [15:0] rdata;
    logic        rsp_valid;
    logic [5:0]  rsp_addr;
    logic [15:0] rsp_data;
    logic        rsp_err;
    logic        timeout_err;
    logic        busy;
    logic [15:0] wr_done;
    logic [15:0] rd_done;

    mem_initiator #(
        .ADDR_WIDTH (6),
        .DATA_WIDTH (16),
        .FIFO_DEPTH (4),
        .TIMEOUT    (15)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .cmd_valid   (cmd_valid),
        .cmd_ready   (cmd_ready),
        .cmd_wr_rd   (cmd_wr_rd),
        .cmd_addr    (cmd_addr),
        .cmd_wdata   (cmd_wdata),
        .addr        (addr),
        .wr_rd       (wr_rd),
        .wdata       (wdata),
        .valid       (valid),
        .ready       (ready),
        .rdata       (rdata),
        .rsp_valid   (rsp_valid),
        .rsp_addr    (rsp_addr),
        .rsp_data    (rsp_data),
        .rsp_err     (rsp_err),
        .timeout_err (timeout_err),
        .busy        (busy),
        .wr_done     (wr_done),
        .rd_done     (rd_done)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    typedef struct {
        logic [5:0]  addr;
        logic [15:0] data;
        logic        err;
    } rsp_t;

    rsp_t        sb[$];
    rsp_t        exp_rsp;
    logic [15:0] mem     [64];
    logic [15:0] ref_mem [64];
    int          mode_wait   = 0;
    bit          never_ready = 1'b0;
    int          vcycles     = 0;
    logic        prev_rsp    = 1'b0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Memory model: ready after mode_wait stalled cycles of valid, or never.
    assign rdata = mem[addr];
    always @(posedge clk) begin
        if (valid && ready && wr_rd) mem[addr] <= wdata;
    end
    always @(negedge clk) begin
        if (valid) begin
            vcycles = vcycles + 1;
            ready   = !never_ready && (vcycles > mode_wait);
        end else begin
            vcycles = 0;
            ready   = 1'b0;
        end
    end

    // Response monitor against the scoreboard.
    always @(negedge clk) begin
        if (rsp_valid) begin
            check("rsp_pulse", prev_rsp, 0);
            check("rsp_expected", sb.size() != 0, 1);
            if (sb.size() != 0) begin
                exp_rsp = sb.pop_front();
                check("rsp_addr", rsp_addr, exp_rsp.addr);
                check("rsp_data", rsp_data, exp_rsp.data);
                check("rsp_err", rsp_err, exp_rsp.err);
            end
        end
        prev_rsp = rsp_valid;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic wr, input logic [5:0] a, input logic [15:0] d,
                        input bit exp_ok, input bit track, output int edges);
        logic acc;
        rsp_t e;
        acc       = 1'b0;
        edges     = 0;
        cmd_wr_rd = wr;
        cmd_addr  = a;
        cmd_wdata = d;
        cmd_valid = 1'b1;
        while (!acc && edges < 300) begin
            @(negedge clk);
            acc = cmd_ready;
            @(posedge clk);
            #1;
            edges++;
        end
        cmd_valid = 1'b0;
        check("send_accept", acc, 1);
        if (track) begin
            if (wr) begin
                if (exp_ok) ref_mem[a] = d;
            end else begin
                e.addr = a;
                e.data = exp_ok ? ref_mem[a] : 16'h0000;
                e.err  = !exp_ok;
                sb.push_back(e);
            end
        end
    endtask

    task automatic wait_idle(input string tag, input int budget);
        int n;
        n = 0;
        while (busy && n < budget) begin
            tick();
            n++;
        end
        check(tag, busy, 0);
        tick();
        tick();
    endtask

    // Counts cycles valid stays high, checking the request fields hold still.
    task automatic measure(input logic [5:0] a, input logic [15:0] d, output int cnt);
        int n;
        n   = 0;
        cnt = 0;
        while (!valid && n < 20) begin
            tick();
            n++;
        end
        while (valid && cnt < 100) begin
            if (addr !== a || wdata !== d) check("req_stable", {addr, wdata}, {a, d});
            cnt++;
            tick();
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: observed no finish, expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int e;
        int cnt;

        // Reset
        rst = 1'b1;
        repeat (2) tick();
        check("rst_valid", valid, 0);
        check("rst_cmd_ready", cmd_ready, 1);
        check("rst_busy", busy, 0);
        check("rst_wr_done", wr_done, 0);
        check("rst_rd_done", rd_done, 0);
        check("rst_timeout_err", timeout_err, 0);
        check("rst_rsp_valid", rsp_valid, 0);
        rst = 1'b0;
        tick();

        // Write then read, zero wait; also the 2-cycle accept-to-request latency
        send(1'b1, 6'h05, 16'hA5A5, 1'b1, 1'b1, e);
        check("lat_valid_low", valid, 0);
        tick();
        check("lat_valid_high", valid, 1);
        check("req_addr", addr, 6'h05);
        check("req_wr_rd", wr_rd, 1);
        check("req_wdata", wdata, 16'hA5A5);
        send(1'b0, 6'h05, 16'h0000, 1'b1, 1'b1, e);
        wait_idle("idle_wr_rd", 50);
        check("wr_done_1", wr_done, 1);
        check("rd_done_1", rd_done, 1);
        check("sb_empty_1", sb.size(), 0);

        // Wait states: ready after 3 stalled cycles
        mode_wait = 3;
        send(1'b1, 6'h0A, 16'h1234, 1'b1, 1'b1, e);
        measure(6'h0A, 16'h1234, cnt);
        check("wait_valid_cycles", cnt, 4);
        check("wait_wr_done", wr_done, 2);
        send(1'b0, 6'h0A, 16'h0000, 1'b1, 1'b1, e);
        wait_idle("idle_wait", 50);
        check("wait_rd_done", rd_done, 2);

        // Read timeout
        never_ready = 1'b1;
        send(1'b0, 6'h3F, 16'h0000, 1'b0, 1'b1, e);
        check("to_err_before", timeout_err, 0);
        measure(6'h3F, 16'h0000, cnt);
        check("to_valid_cycles", cnt, 15);
        check("to_err_rise", timeout_err, 1);
        wait_idle("idle_to", 50);
        repeat (5) tick();
        check("to_err_sticky", timeout_err, 1);
        check("to_rd_done", rd_done, 2);
        check("to_wr_done", wr_done, 2);

        // FIFO full: 1 in REQ + 4 buffered, 6th waits for the first timeout
        cnt = 0;
        for (int i = 0; i < 5; i++) begin
            send(1'b0, 6'(6'h20 + i), 16'h0000, 1'b0, 1'b1, e);
            cnt += e;
        end
        check("full_accept_edges", cnt, 5);
        check("full_cmd_ready", cmd_ready, 0);
        send(1'b0, 6'h25, 16'h0000, 1'b0, 1'b1, e);
        check("full_sixth_wait", e, 14);
        wait_idle("idle_full", 300);
        check("full_rd_done", rd_done, 2);
        check("full_sb_empty", sb.size(), 0);

        // Reset mid-operation with 3 queued commands
        for (int i = 0; i < 4; i++) begin
            send(1'b0, 6'(6'h30 + i), 16'h0000, 1'b0, 1'b0, e);
        end
        check("mid_valid", valid, 1);
        check("mid_busy", busy, 1);
        rst = 1'b1;
        tick();
        check("mid_rst_valid", valid, 0);
        check("mid_rst_busy", busy, 0);
        check("mid_rst_cmd_ready", cmd_ready, 1);
        rst         = 1'b0;
        never_ready = 1'b0;
        mode_wait   = 0;
        cnt         = 0;
        repeat (40) begin
            tick();
            if (valid) cnt++;
        end
        check("mid_no_requests", cnt, 0);
        check("mid_wr_done", wr_done, 0);
        check("mid_rd_done", rd_done, 0);
        check("mid_timeout_err", timeout_err, 0);

        // Normal operation resumes after reset
        send(1'b0, 6'h05, 16'h0000, 1'b1, 1'b1, e);
        wait_idle("idle_post", 50);
        check("post_rd_done", rd_done, 1);
        check("post_sb_empty", sb.size(), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/mem_initiator.md
# mem_initiator

Bus-master counterpart of the `memory` block. It accepts read and write commands on a simple command port and buffers them in a small FIFO. It drives them onto the memory's `valid`/`ready` interface one transaction at a time, with `addr`/`wr_rd`/`wdata` held stable. It returns read data on a response port and aborts any transaction the memory never acknowledges, flagging a timeout.

## Interface
- `ADDR_WIDTH`, 6, memory address width
- `DATA_WIDTH`, 16, data width
- `FIFO_DEPTH`, 4, command FIFO entries (power of 2, ≥2)
- `TIMEOUT`, 15, max cycles `valid` may stay high without `ready` (≥1)

Single clock `clk`; reset `rst` is synchronous and active-high.

- `clk` in 1 — clock, rising edge
- `rst` in 1 — synchronous, active-high reset
- `cmd_valid` in 1 — command offered
- `cmd_ready` out 1 — command FIFO not full
- `cmd_wr_rd` in 1 — 1 = write, 0 = read
- `cmd_addr` in ADDR_WIDTH — command address
- `cmd_wdata` in DATA_WIDTH — write data (ignored for reads)
- `addr` out ADDR_WIDTH — to memory
- `wr_rd` out 1 — to memory, 1 = write
- `wdata` out DATA_WIDTH — to memory
- `valid` out 1 — transaction request to memory
- `ready` in 1 — memory acknowledge
- `rdata` in DATA_WIDTH — memory read data, sampled on the completion cycle
- `rsp_valid` out 1 — one-cycle pulse per finished read
- `rsp_addr` out ADDR_WIDTH — address of the returned read
- `rsp_data` out DATA_WIDTH — read data (0 when `rsp_err`)
- `rsp_err` out 1 — qualifies `rsp_valid`: the read timed out
- `timeout_err` out 1 — sticky, set by any timeout
- `busy` out 1 — FIFO non-empty or FSM not IDLE
- `wr_done` out 16 — completed writes, wraps at 0xFFFF→0
- `rd_done` out 16 — completed reads (timeouts excluded), wraps

## Operation
- **Command push:** occurs when `cmd_valid && cmd_ready`. `cmd_ready = !full`, combinational from FIFO state.
- **Simultaneous push and pop:** legal whenever the FIFO is not full. Occupancy stays unchanged.
- **FSM states:**
  - IDLE: if the FIFO is non-empty, pop the head into the `addr`/`wr_rd`/`wdata` registers, clear the wait counter, and go to REQ. `valid` is 0.
  - REQ: `valid` = 1, outputs held constant.
    - On `ready`: transaction complete. For a read, register `rdata` → `rsp_data`, set `rsp_addr`, pulse `rsp_valid`, increment `rd_done`. For a write, increment `wr_done`. Go to IDLE.
    - Otherwise the wait counter increments. When it reaches TIMEOUT, the transaction is dropped: set `timeout_err`; for a read, pulse `rsp_valid` with `rsp_err` = 1 and `rsp_data` = 0. Go to IDLE. No counter increments.
- **Ordering:** commands execute strictly in FIFO order and are never reordered or retried.
- **Ready outside REQ:** `ready` while `valid` = 0 is ignored.
- **Reset:** all outputs are 0 except `cmd_ready` = 1. FIFO pointers, counters, `timeout_err` and the FSM (IDLE) are cleared. A reset during REQ drops `valid` at that edge, and buffered commands are discarded.

## Timing
- **Accept to request:** command accepted at edge N while IDLE and empty → FIFO write at N → IDLE pops at N+1 → `valid` high from N+1 to N+2 onward, i.e. visible in the cycle after the second edge. Latency is 2 cycles.
- **Completion:** happens at the first edge where `valid && ready` = 1. `valid` falls after that edge.
- **Read response:** `rsp_valid`/`rsp_data` appear in the cycle following completion, for exactly 1 cycle.
- **Back-to-back commands:** `valid` is low for exactly 1 cycle (the IDLE cycle) between transactions. Maximum throughput is 1 transaction per 2 cycles with zero-wait `ready`.
- **Timeout:** `valid` is high for exactly TIMEOUT cycles, then low. `timeout_err` rises the cycle after the drop edge.
- **Stability:** `addr`, `wr_rd` and `wdata` change only on the IDLE→REQ edge.

## Test plan
- **Reset:** hold `rst` 2 cycles → `valid` = 0, `cmd_ready` = 1, `busy` = 0, `wr_done` = `rd_done` = 0, `timeout_err` = 0.
- **Write then read:** write addr 0x05 data 0xA5A5, then read addr 0x05, memory `ready` with zero wait → `wr_done` = 1, `rd_done` = 1, `rsp_valid` pulse with `rsp_addr` = 0x05, `rsp_data` = 0xA5A5, `rsp_err` = 0.
- **FIFO full:** with `ready` tied 0 and TIMEOUT = 15, push 5 commands → `cmd_ready` falls after the 5th accept (1 in REQ + 4 buffered). The 6th offer is held off until the first timeout.
- **Wait states:** `ready` delayed 3 cycles → `valid`, `addr` and `wdata` stable for 4 cycles; `valid` drops after the `ready` edge; exactly one completion.
- **Read timeout:** read to addr 0x3F with `ready` never asserted → `valid` high exactly 15 cycles, then `rsp_valid` with `rsp_err` = 1 and `rsp_data` = 0, `timeout_err` = 1 sticky, `rd_done` = 0.
- **Reset mid-operation:** assert `rst` during REQ with 3 queued commands → next cycle `valid` = 0, `busy` = 0, and no responses are ever issued for the discarded commands.
